// File: rtl/ddr_rd_ctrl_if.sv
// Read-request / DDR native-port bundle between memInt, ddr_rd_ctrl and the DDR controller.
interface ddr_rd_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512
) ();

  // memInt side
  logic              ddr_rd;
  logic [ADDR_W-1:0] readAdd;
  logic              ddr_rd_valid;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_done;

  // DDR native command port
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [7:0]        mem_cmd_len;

  // DDR native read-data port (no backpressure)
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_last;

  logic              err;

  // Environment side: memInt requester plus DDR responder.
  modport master (
    output ddr_rd, readAdd, mem_cmd_ready, mem_rdata_valid, mem_rdata, mem_rdata_last,
    input  ddr_rd_valid, ddr_rd_data, ddr_rd_done, mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    input  err
  );

  // Read controller side.
  modport slave (
    input  ddr_rd, readAdd, mem_cmd_ready, mem_rdata_valid, mem_rdata, mem_rdata_last,
    output ddr_rd_valid, ddr_rd_data, ddr_rd_done, mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    output err
  );

endinterface

// File: rtl/ddr_rd_ctrl.sv
// DDR read controller: turns a memInt read request into one fixed-length burst command,
// forwards the returned beats with one cycle of latency, flags the final beat, and
// guards against length violations, stray beats and a stalled response.
module ddr_rd_ctrl #(
  parameter int unsigned BURST_BEATS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned TIMEOUT     = 1023
) (
  input logic          clk,
  input logic          rst,
  ddr_rd_ctrl_if.slave bus
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic is_last;
  logic timeout_hit;

  assign is_last     = (beat_cnt_q == 8'(BURST_BEATS - 1));
  assign timeout_hit = (to_cnt_q == ToW'(TIMEOUT - 1));

  // Next-state and registered-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    beat_cnt_d  = beat_cnt_q;
    to_cnt_d    = to_cnt_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        // No burst is outstanding, so any beat here is stray.
        if (bus.mem_rdata_valid) err_d = 1'b1;
        if (bus.ddr_rd) begin
          addr_d      = bus.readAdd & ~ADDR_W'(64'h3f);
          cmd_valid_d = 1'b1;
          state_d     = StCmd;
        end
      end

      StCmd: begin
        if (bus.mem_rdata_valid) err_d = 1'b1;
        if (bus.mem_cmd_ready) begin
          cmd_valid_d = 1'b0;
          beat_cnt_d  = '0;
          to_cnt_d    = '0;
          state_d     = StData;
        end
      end

      StData: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A final beat arriving on the timeout cycle still completes normally.
        if (timeout_hit && !(bus.mem_rdata_valid && is_last)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (bus.mem_rdata_valid) begin
          valid_d    = 1'b1;
          data_d     = bus.mem_rdata;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // The DDR's last flag is only cross-checked; our own count ends the burst.
          if (bus.mem_rdata_last != is_last) err_d = 1'b1;
          if (is_last) begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        // ddr_rd is deliberately ignored for this one cycle.
        if (bus.mem_rdata_valid) err_d = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
      to_cnt_q    <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_addr  = addr_q;
  assign bus.mem_cmd_len   = 8'(BURST_BEATS - 1);
  assign bus.ddr_rd_valid  = valid_q;
  assign bus.ddr_rd_data   = data_q;
  assign bus.ddr_rd_done   = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// Directed bench for ddr_rd_ctrl (BURST_BEATS=4, TIMEOUT=20).
module tb_ddr_rd_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  ddr_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr_rd_ctrl #(
    .BURST_BEATS(4),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = d;
    bus.mem_rdata_last  = last;
    tick();
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic dn);
    chk({tag, ".valid"}, bus.ddr_rd_valid, v);
    chk({tag, ".data"}, bus.ddr_rd_data, d);
    chk({tag, ".done"}, bus.ddr_rd_done, dn);
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 1'b0, '0, 1'b0);
    chk({tag, ".cmd_valid"}, bus.mem_cmd_valid, 1'b0);
    chk({tag, ".cmd_addr"}, bus.mem_cmd_addr, '0);
    chk({tag, ".err"}, bus.err, 1'b0);
  endtask

  initial begin
    bus.ddr_rd          = 1'b0;
    bus.readAdd         = '0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_rdata_last  = 1'b0;

    // Reset state
    tick();
    tick();
    chk_reset("reset");
    chk("reset.len", bus.mem_cmd_len, 3);
    rst = 1'b1;
    tick();

    // Single burst, immediate ready, back-to-back beats
    bus.ddr_rd        = 1'b1;
    bus.readAdd       = 32'h1047;
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.ddr_rd = 1'b0;
    chk("t1.cmd_valid", bus.mem_cmd_valid, 1'b1);
    chk("t1.cmd_addr", bus.mem_cmd_addr, 32'h1040);
    chk("t1.len", bus.mem_cmd_len, 3);
    tick();
    chk("t1.cmd_valid_drop", bus.mem_cmd_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'hc0 + k), k == 3);
      chk_out($sformatf("t1.beat%0d", k), 1'b1, DW'(8'hc0 + k), k == 3);
    end
    tick();
    chk_out("t1.after", 1'b0, DW'(8'hc3), 1'b0);
    chk("t1.err", bus.err, 1'b0);

    // Command stall with changing readAdd, then gapped beats
    bus.ddr_rd        = 1'b1;
    bus.readAdd       = 32'h2000_00ff;
    bus.mem_cmd_ready = 1'b0;
    tick();
    bus.ddr_rd  = 1'b0;
    bus.readAdd = 32'hffff_ffff;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2.stall%0d.valid", i), bus.mem_cmd_valid, 1'b1);
      chk($sformatf("t2.stall%0d.addr", i), bus.mem_cmd_addr, 32'h2000_00c0);
      if (i == 5) bus.mem_cmd_ready = 1'b1;
      tick();
    end
    chk("t2.cmd_valid_drop", bus.mem_cmd_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'h11 + k), k == 3);
      chk_out($sformatf("t2.beat%0d", k), 1'b1, DW'(8'h11 + k), k == 3);
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          chk_out($sformatf("t2.gap%0d_%0d", k, g), 1'b0, DW'(8'h11 + k), 1'b0);
        end
      end
    end
    tick();
    chk_out("t2.after", 1'b0, DW'(8'h14), 1'b0);
    chk("t2.err", bus.err, 1'b0);

    // Held request across done, then a stray beat in IDLE
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h3000;
    tick();
    chk("t5.cmd1", bus.mem_cmd_valid, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'h50 + k), k == 3);
      chk_out($sformatf("t5.a%0d", k), 1'b1, DW'(8'h50 + k), k == 3);
    end
    tick();
    chk("t5.done_plus1.cmd", bus.mem_cmd_valid, 1'b0);
    chk("t5.done_plus1.done", bus.ddr_rd_done, 1'b0);
    tick();
    chk("t5.done_plus2.cmd", bus.mem_cmd_valid, 1'b1);
    bus.ddr_rd = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'h60 + k), k == 3);
      chk_out($sformatf("t5.b%0d", k), 1'b1, DW'(8'h60 + k), k == 3);
    end
    tick();
    chk("t5.err_before_stray", bus.err, 1'b0);
    beat(DW'(16'hdead), 1'b0);
    chk_out("t5.stray", 1'b0, DW'(8'h63), 1'b0);
    chk("t5.stray.err", bus.err, 1'b1);

    // Reset mid-burst, then a clean burst
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h4000;
    tick();
    bus.ddr_rd = 1'b0;
    tick();
    beat(DW'(8'h70), 1'b0);
    beat(DW'(8'h71), 1'b0);
    chk_out("t6.beat1", 1'b1, DW'(8'h71), 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset("t6.reset");
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h5010;
    tick();
    bus.ddr_rd = 1'b0;
    chk("t6.cmd_valid", bus.mem_cmd_valid, 1'b1);
    chk("t6.cmd_addr", bus.mem_cmd_addr, 32'h5000);
    tick();
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'h80 + k), k == 3);
      chk_out($sformatf("t6.beat%0d", k), 1'b1, DW'(8'h80 + k), k == 3);
    end
    chk("t6.err", bus.err, 1'b0);
    tick();

    // Early last on beat 2 of 4
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h40;
    tick();
    bus.ddr_rd = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      beat(DW'(8'ha0 + k), k == 1);
      chk_out($sformatf("t3.beat%0d", k), 1'b1, DW'(8'ha0 + k), k == 3);
      chk($sformatf("t3.err%0d", k), bus.err, k >= 1);
    end
    tick();
    chk("t3.done_once", bus.ddr_rd_done, 1'b0);

    // Plain reset to clear err before the timeout case
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2.err", bus.err, 1'b0);

    // Timeout: only 2 of 4 beats arrive
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h6000;
    tick();
    bus.ddr_rd = 1'b0;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (c <= 2) beat(DW'(8'h90 + c - 1), 1'b0);
      else tick();
      if (c < 20) begin
        chk_out($sformatf("t4.c%0d", c), c <= 2, (c == 1) ? DW'(8'h90) : DW'(8'h91), 1'b0);
        chk($sformatf("t4.c%0d.err", c), bus.err, 1'b0);
      end else begin
        chk_out("t4.timeout", 1'b0, DW'(8'h91), 1'b1);
        chk("t4.timeout.err", bus.err, 1'b1);
      end
    end
    bus.ddr_rd  = 1'b1;
    bus.readAdd = 32'h7000;
    tick();
    chk("t4.post.done", bus.ddr_rd_done, 1'b0);
    chk("t4.post.cmd", bus.mem_cmd_valid, 1'b0);
    tick();
    chk("t4.idle_reissue.cmd", bus.mem_cmd_valid, 1'b1);
    chk("t4.idle_reissue.addr", bus.mem_cmd_addr, 32'h7000);
    chk("t4.err_sticky", bus.err, 1'b1);
    bus.ddr_rd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
